// File: rtl/sega_pad_scanner_pkg.sv
// Shared definitions for the DB9 Sega pad scanner: pad-type codes, DB9 bit positions,
// scan FSM states and the extra-button payload.
package sega_pad_scanner_pkg;

    localparam int unsigned PAD_W = 6;

    localparam logic [1:0] PADTYPE_NONE = 2'b00;
    localparam logic [1:0] PADTYPE_3BTN = 2'b01;
    localparam logic [1:0] PADTYPE_6BTN = 2'b10;

    localparam int unsigned DB9_R  = 0;
    localparam int unsigned DB9_L  = 1;
    localparam int unsigned DB9_D  = 2;
    localparam int unsigned DB9_U  = 3;
    localparam int unsigned DB9_F1 = 4;
    localparam int unsigned DB9_F2 = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PH0, ST_PH1, ST_PH2, ST_PH3,
        ST_PH4, ST_PH5, ST_PH6, ST_PH7
    } scan_state_e;

    // Active-high extra buttons, MSB first: {MODE,X,Y,Z,START,A}
    typedef struct packed {
        logic mode;
        logic x;
        logic y;
        logic z;
        logic start;
        logic a;
    } ext_buttons_t;

    // SELECT is low only in the odd phases
    function automatic logic select_level(input scan_state_e s);
        case (s)
            ST_PH1, ST_PH3, ST_PH5, ST_PH7: select_level = 1'b0;
            default:                        select_level = 1'b1;
        endcase
    endfunction

    function automatic scan_state_e next_phase(input scan_state_e s);
        case (s)
            ST_IDLE: next_phase = ST_PH0;
            ST_PH0:  next_phase = ST_PH1;
            ST_PH1:  next_phase = ST_PH2;
            ST_PH2:  next_phase = ST_PH3;
            ST_PH3:  next_phase = ST_PH4;
            ST_PH4:  next_phase = ST_PH5;
            ST_PH5:  next_phase = ST_PH6;
            ST_PH6:  next_phase = ST_PH7;
            default: next_phase = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/joy_phase_timer.sv
// Loadable down-counter that stops at zero; tc_c flags the terminal count.
module joy_phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc_c = (cnt == '0);

endmodule

// File: rtl/sega_pad_scanner.sv
// Drives SELECT on one DB9 port, detects Atari / Sega 3-button / Sega 6-button pads and
// presents a low-active direction+fire word plus the Sega extra buttons.
module sega_pad_scanner
    import sega_pad_scanner_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 280,
    parameter int unsigned IDLE_CYCLES  = 56000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_en,
    input  logic [PAD_W-1:0] pad_in,
    output logic             select_out,
    output logic [PAD_W-1:0] db9joy_out,
    output logic [5:0]       ext_buttons,
    output logic [1:0]       pad_type,
    output logic             scan_done
);

    localparam int unsigned CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD  = CNT_W'(IDLE_CYCLES - 1);

    logic [PAD_W-1:0] sync_q;
    logic [PAD_W-1:0] s_pad;

    scan_state_e      state;
    scan_state_e      state_nxt;
    logic             restart;
    logic             tc_c;
    logic             phase_end_c;
    logic             tmr_load_c;
    logic [CNT_W-1:0] tmr_val_c;

    logic [PAD_W-1:0] sh_dir;
    logic             sh_sega;
    logic             sh_six;
    ext_buttons_t     sh_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            s_pad  <= '1;
        end else begin
            sync_q <= pad_in;
            s_pad  <= sync_q;
        end
    end

    joy_phase_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (~scan_en),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .tc_c     (tc_c)
    );

    // restart marks an IDLE entered from reset or scan_en=0: the counter sits at 0 there
    // and must first be loaded with a full idle period.
    assign phase_end_c = scan_en && tc_c && !restart;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            restart <= 1'b1;
        end else begin
            state   <= state_nxt;
            restart <= ~scan_en;
        end
    end

    always_comb begin
        state_nxt  = state;
        tmr_load_c = 1'b0;
        tmr_val_c  = PHASE_LOAD;
        if (!scan_en) begin
            state_nxt = ST_IDLE;
        end else if (restart) begin
            tmr_load_c = 1'b1;
            tmr_val_c  = IDLE_LOAD;
        end else if (phase_end_c) begin
            state_nxt  = next_phase(state);
            tmr_load_c = 1'b1;
            tmr_val_c  = (state_nxt == ST_IDLE) ? IDLE_LOAD : PHASE_LOAD;
        end
    end

    // Shadow capture at phase end, atomic commit at the end of PH7, passthrough otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            select_out  <= 1'b1;
            db9joy_out  <= '1;
            ext_buttons <= '0;
            pad_type    <= PADTYPE_NONE;
            scan_done   <= 1'b0;
            sh_dir      <= '0;
            sh_sega     <= 1'b0;
            sh_six      <= 1'b0;
            sh_ext      <= '0;
        end else begin
            scan_done  <= 1'b0;
            select_out <= select_level(state_nxt);
            if (!scan_en) begin
                db9joy_out  <= s_pad;
                ext_buttons <= '0;
                pad_type    <= PADTYPE_NONE;
                sh_dir      <= '0;
                sh_sega     <= 1'b0;
                sh_six      <= 1'b0;
                sh_ext      <= '0;
            end else begin
                if (phase_end_c) begin
                    case (state)
                        ST_PH0: sh_dir <= ~s_pad;
                        ST_PH1: begin
                            sh_ext.a     <= ~s_pad[DB9_F1];
                            sh_ext.start <= ~s_pad[DB9_F2];
                            sh_sega      <= !s_pad[DB9_L] && !s_pad[DB9_R];
                        end
                        ST_PH5: sh_six <= !(s_pad[DB9_U] || s_pad[DB9_D] ||
                                            s_pad[DB9_L] || s_pad[DB9_R]);
                        ST_PH6: begin
                            sh_ext.z    <= ~s_pad[DB9_U];
                            sh_ext.y    <= ~s_pad[DB9_D];
                            sh_ext.x    <= ~s_pad[DB9_L];
                            sh_ext.mode <= ~s_pad[DB9_R];
                        end
                        default: ;
                    endcase
                end

                if (phase_end_c && state == ST_PH7) begin
                    scan_done <= 1'b1;
                    if (sh_sega) begin
                        db9joy_out  <= ~sh_dir;
                        pad_type    <= sh_six ? PADTYPE_6BTN : PADTYPE_3BTN;
                        ext_buttons <= sh_six ? sh_ext : {4'b0000, sh_ext.start, sh_ext.a};
                    end else begin
                        db9joy_out  <= s_pad;
                        pad_type    <= PADTYPE_NONE;
                        ext_buttons <= '0;
                    end
                end else if (pad_type == PADTYPE_NONE) begin
                    db9joy_out <= s_pad;
                end
            end
        end
    end

endmodule
